// File: rtl/cross_arb_pkg.sv
// Shared types and helpers for the cross-product arbiter.
// Optional full-result port: CROSS_ARB_FULL_RESULT_EN.
package cross_arb_pkg;

  localparam int CA_OPW = 11;
  localparam int TAGW   = 3;
  localparam int NMAX   = 8;

  typedef enum logic {
    IDLE,
    GRANT
  } fsm_e;

  typedef struct packed {
    logic signed [CA_OPW-1:0] ax;
    logic signed [CA_OPW-1:0] ay;
    logic signed [CA_OPW-1:0] bx;
    logic signed [CA_OPW-1:0] by;
    logic [TAGW-1:0]          tag;
  } cp_beat_t;

  // First set request at or after ptr, wrapping modulo n.
  function automatic logic [TAGW-1:0] rr_pick(
    input logic [NMAX-1:0] req,
    input logic [TAGW-1:0] ptr,
    input int              n
  );
    int              idx;
    logic [TAGW-1:0] idx3;
    rr_pick = ptr;
    for (int k = n - 1; k >= 0; k--) begin
      idx  = (int'(ptr) + k) % n;
      idx3 = idx[TAGW-1:0];
      if (req[idx3]) rr_pick = idx3;
    end
  endfunction

endpackage

// File: rtl/cross_mul_core.sv
// S2/S3 datapath: sign-magnitude products, difference, flags.
// CROSS_ARB_FULL_RESULT_EN also registers the difference.
module cross_mul_core
  import cross_arb_pkg::*;
#(
  parameter int OPW = CA_OPW
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s1_vld_i,
  input  logic                  s2_vld_i,
  input  logic signed [OPW-1:0] ax_i,
  input  logic signed [OPW-1:0] ay_i,
  input  logic signed [OPW-1:0] bx_i,
  input  logic signed [OPW-1:0] by_i,
  output logic                  pos_o,
  output logic                  zero_o
`ifdef CROSS_ARB_FULL_RESULT_EN
  ,
  output logic signed [2*OPW-1:0] cross_o
`endif
);

  localparam int MW = 2 * OPW - 1;
  localparam int DW = 2 * OPW;

  // -2^(OPW-1) maps to 2^(OPW-1), still fits OPW unsigned bits
  function automatic logic [OPW-1:0] mag(
    input logic signed [OPW-1:0] a
  );
    mag = a[OPW-1] ? (~a + 1'b1) : a;
  endfunction

  logic [MW-1:0]        m0_d, m1_d, m0_q, m1_q;
  logic                 s0_d, s1_d, s0_q, s1_q;
  logic signed [DW-1:0] p0, p1, diff_d;
  logic                 pos_d, zero_d;
  logic                 pos_q, zero_q;

  // S2 inputs: magnitude products and product signs
  always_comb begin
    m0_d = MW'(mag(ax_i)) * MW'(mag(by_i));
    m1_d = MW'(mag(ay_i)) * MW'(mag(bx_i));
    s0_d = ax_i[OPW-1] ^ by_i[OPW-1];
    s1_d = ay_i[OPW-1] ^ bx_i[OPW-1];
  end

  // S2 register, loaded only for a valid beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0_q <= '0;
      m1_q <= '0;
      s0_q <= 1'b0;
      s1_q <= 1'b0;
    end else if (s1_vld_i) begin
      m0_q <= m0_d;
      m1_q <= m1_d;
      s0_q <= s0_d;
      s1_q <= s1_d;
    end
  end

  // S3 inputs: signed difference and its flags
  always_comb begin
    p0 = $signed({1'b0, m0_q});
    p1 = $signed({1'b0, m1_q});
    if (s0_q) p0 = -p0;
    if (s1_q) p1 = -p1;
    diff_d = p0 - p1;
    zero_d = (diff_d == '0);
    pos_d  = !diff_d[DW-1] && !zero_d;
  end

  // S3 flags, held between strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (s2_vld_i) begin
      pos_q  <= pos_d;
      zero_q <= zero_d;
    end
  end

  assign pos_o  = pos_q;
  assign zero_o = zero_q;

`ifdef CROSS_ARB_FULL_RESULT_EN
  logic signed [DW-1:0] diff_q;

  // S3 full difference, held like the flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_q <= '0;
    end else if (s2_vld_i) begin
      diff_q <= diff_d;
    end
  end

  assign cross_o = diff_q;
`endif

endmodule

// File: rtl/cross_product_arbiter.sv
// Round-robin burst arbiter over one 3-stage cross-product unit.
// CROSS_ARB_FULL_RESULT_EN adds the rsp_cross output port.
module cross_product_arbiter
  import cross_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int OPW       = CA_OPW,
  parameter int MAX_BURST = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ-1:0]       op_valid,
  input  logic [N_REQ*OPW-1:0]   op_ax,
  input  logic [N_REQ*OPW-1:0]   op_ay,
  input  logic [N_REQ*OPW-1:0]   op_bx,
  input  logic [N_REQ*OPW-1:0]   op_by,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic                   rsp_pos,
  output logic                   rsp_zero
`ifdef CROSS_ARB_FULL_RESULT_EN
  ,
  output logic signed [2*OPW-1:0] rsp_cross
`endif
);

  fsm_e             state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [TAGW-1:0]  idx_q, idx_d;
  logic [TAGW-1:0]  ptr_q, ptr_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [NMAX-1:0]  req_w;
  logic [TAGW-1:0]  pick;
  logic             accept, req_cur, leave;

  cp_beat_t         beat_d, beat_q;
  logic             v1_q, v2_q;
  logic [TAGW-1:0]  tag2_q;
  logic [N_REQ-1:0] rsp_d, rsp_q;

  // Granted requester's status and the round-robin candidate
  always_comb begin
    req_w = '0;
    req_w[N_REQ-1:0] = req;
    pick    = rr_pick(req_w, ptr_q, N_REQ);
    accept  = 1'b0;
    req_cur = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (idx_q == i[TAGW-1:0]) begin
        accept  = gnt_q[i] & op_valid[i];
        req_cur = req[i];
      end
    end
    leave = (state_q == GRANT) &&
            (!req_cur ||
             (accept && cnt_q == 4'(MAX_BURST - 1)));
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (|req) state_d = GRANT;
      GRANT:   if (leave) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: grant, owner, burst count, rotation pointer
  always_comb begin
    gnt_d = gnt_q;
    idx_d = idx_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          idx_d = pick;
          cnt_d = '0;
          for (int i = 0; i < N_REQ; i++)
            gnt_d[i] = (pick == i[TAGW-1:0]);
        end
      end
      GRANT: begin
        if (accept) cnt_d = cnt_q + 4'd1;
        if (leave) begin
          gnt_d = '0;
          ptr_d = (idx_q == TAGW'(N_REQ - 1)) ?
                  '0 : idx_q + 1'b1;
        end
      end
      default: gnt_d = '0;
    endcase
  end

  // Arbitration registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt_q <= '0;
      idx_q <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      gnt_q <= gnt_d;
      idx_q <= idx_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // S1 operand mux from the granted requester
  always_comb begin
    beat_d     = '0;
    beat_d.tag = idx_q;
    for (int i = 0; i < N_REQ; i++) begin
      if (idx_q == i[TAGW-1:0]) begin
        beat_d.ax = op_ax[i*OPW +: OPW];
        beat_d.ay = op_ay[i*OPW +: OPW];
        beat_d.bx = op_bx[i*OPW +: OPW];
        beat_d.by = op_by[i*OPW +: OPW];
      end
    end
  end

  // Response strobe decoded from the S2 tag
  always_comb begin
    rsp_d = '0;
    for (int i = 0; i < N_REQ; i++)
      rsp_d[i] = v2_q && (tag2_q == i[TAGW-1:0]);
  end

  // S1 register and tag pipe; reset flushes all valids
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1_q   <= 1'b0;
      beat_q <= '0;
      v2_q   <= 1'b0;
      tag2_q <= '0;
      rsp_q  <= '0;
    end else begin
      v1_q  <= accept;
      v2_q  <= v1_q;
      rsp_q <= rsp_d;
      if (accept) beat_q <= beat_d;
      if (v1_q)   tag2_q <= beat_q.tag;
    end
  end

  cross_mul_core #(
    .OPW (OPW)
  ) u_core (
    .clk      (clk),
    .rst_n    (reset),
    .s1_vld_i (v1_q),
    .s2_vld_i (v2_q),
    .ax_i     (beat_q.ax),
    .ay_i     (beat_q.ay),
    .bx_i     (beat_q.bx),
    .by_i     (beat_q.by),
    .pos_o    (rsp_pos),
    .zero_o   (rsp_zero)
`ifdef CROSS_ARB_FULL_RESULT_EN
    ,
    .cross_o  (rsp_cross)
`endif
  );

  assign gnt       = gnt_q;
  assign rsp_valid = rsp_q;

endmodule

// File: tb/tb_cross_product_arbiter.sv
// Directed bench for cross_product_arbiter.
// Covers rsp_cross when CROSS_ARB_FULL_RESULT_EN is defined.
module tb_cross_product_arbiter;

  localparam int N  = 4;
  localparam int W  = 11;
  localparam int MB = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req, op_valid;
  logic [N*W-1:0] op_ax, op_ay, op_bx, op_by;
  logic [N-1:0]   gnt, rsp_valid;
  logic           rsp_pos, rsp_zero;
`ifdef CROSS_ARB_FULL_RESULT_EN
  logic signed [2*W-1:0] rsp_cross;
`endif

  int errors = 0;
  int checks = 0;
  int rsp_cnt[N];
  logic [N-1:0] exp_oh;

  always #5 clk = ~clk;

  cross_product_arbiter #(
    .N_REQ     (N),
    .OPW       (W),
    .MAX_BURST (MB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .op_valid  (op_valid),
    .op_ax     (op_ax),
    .op_ay     (op_ay),
    .op_bx     (op_bx),
    .op_by     (op_by),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_pos   (rsp_pos),
    .rsp_zero  (rsp_zero)
`ifdef CROSS_ARB_FULL_RESULT_EN
    ,
    .rsp_cross (rsp_cross)
`endif
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (rsp_valid[i]) rsp_cnt[i]++;
  endtask

  task automatic clr_cnt();
    for (int i = 0; i < N; i++) rsp_cnt[i] = 0;
  endtask

  task automatic set_ops(input int i, input int ax,
                         input int ay, input int bx,
                         input int by);
    op_ax[i*W +: W] = W'(ax);
    op_ay[i*W +: W] = W'(ay);
    op_bx[i*W +: W] = W'(bx);
    op_by[i*W +: W] = W'(by);
  endtask

  initial begin
    reset    = 1'b0;
    req      = '0;
    op_valid = '0;
    op_ax    = '0;
    op_ay    = '0;
    op_bx    = '0;
    op_by    = '0;
    clr_cnt();
    tick();
    tick();
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_rsp", 32'(rsp_valid), 32'h0);
    check("rst_pos", 32'(rsp_pos), 32'h0);
    check("rst_zero", 32'(rsp_zero), 32'h0);
    reset = 1'b1;
    tick();

    // 3*4 - 0*0 = 12
    req = 4'b0001;
    tick();
    check("a_gnt", 32'(gnt), 32'h1);
    set_ops(0, 3, 0, 0, 4);
    op_valid = 4'b0001;
    tick();
    op_valid = '0;
    req      = '0;
    check("a_rsp_early", 32'(rsp_valid), 32'h0);
    tick();
    check("a_release", 32'(gnt), 32'h0);
    tick();
    check("a_rsp", 32'(rsp_valid), 32'h1);
    check("a_pos", 32'(rsp_pos), 32'h1);
    check("a_zero", 32'(rsp_zero), 32'h0);
    tick();
    check("a_strobe", 32'(rsp_valid), 32'h0);
    check("a_hold", 32'(rsp_pos), 32'h1);

    // 2*2 - 4*1 = 0
    req = 4'b0001;
    tick();
    check("b_gnt", 32'(gnt), 32'h1);
    set_ops(0, 2, 4, 1, 2);
    op_valid = 4'b0001;
    tick();
    op_valid = '0;
    req      = '0;
    tick();
    tick();
    check("b_rsp", 32'(rsp_valid), 32'h1);
    check("b_zero", 32'(rsp_zero), 32'h1);
    check("b_pos", 32'(rsp_pos), 32'h0);

    // back-to-back: (-1024)*(-1024) then 0*0 - 5*3 = -15
    req = 4'b0001;
    tick();
    check("c_gnt", 32'(gnt), 32'h1);
    set_ops(0, -1024, 0, 0, -1024);
    op_valid = 4'b0001;
    tick();
    set_ops(0, 0, 5, 3, 0);
    tick();
    op_valid = '0;
    req      = '0;
    tick();
    check("c1_rsp", 32'(rsp_valid), 32'h1);
    check("c1_pos", 32'(rsp_pos), 32'h1);
    check("c1_zero", 32'(rsp_zero), 32'h0);
`ifdef CROSS_ARB_FULL_RESULT_EN
    check("c1_cross", 32'(rsp_cross), 32'd1048576);
`endif
    tick();
    check("c2_rsp", 32'(rsp_valid), 32'h1);
    check("c2_pos", 32'(rsp_pos), 32'h0);
    check("c2_zero", 32'(rsp_zero), 32'h0);
`ifdef CROSS_ARB_FULL_RESULT_EN
    check("c2_cross", 32'(rsp_cross), 32'hFFFF_FFF1);
`endif
    tick();
    check("c_idle", 32'(rsp_valid), 32'h0);

    // all requesting; pointer is 1 after releasing index 0
    clr_cnt();
    for (int i = 0; i < N; i++) set_ops(i, 1, 0, 0, 1);
    req      = 4'hF;
    op_valid = 4'hF;
    for (int g = 0; g < 5; g++) begin
      exp_oh = 4'b0001 << ((1 + g) % N);
      tick();
      check("d_gnt", 32'(gnt), 32'(exp_oh));
      for (int b = 1; b < MB; b++) begin
        tick();
        check("d_burst", 32'(gnt), 32'(exp_oh));
      end
      tick();
      check("d_bubble", 32'(gnt), 32'h0);
    end
    req      = '0;
    op_valid = '0;
    repeat (4) tick();
    check("d_cnt0", 32'(rsp_cnt[0]), 32'd8);
    check("d_cnt1", 32'(rsp_cnt[1]), 32'd16);
    check("d_cnt2", 32'(rsp_cnt[2]), 32'd8);
    check("d_cnt3", 32'(rsp_cnt[3]), 32'd8);

    // requester 2 drops after 3 beats; pointer is 2
    clr_cnt();
    req      = 4'b0110;
    op_valid = 4'b0110;
    tick();
    check("e_gnt", 32'(gnt), 32'h4);
    for (int b = 0; b < 3; b++) begin
      tick();
      check("e_burst", 32'(gnt), 32'h4);
    end
    req      = 4'b0010;
    op_valid = 4'b0010;
    tick();
    check("e_release", 32'(gnt), 32'h0);
    tick();
    check("e_next", 32'(gnt), 32'h2);
    req = '0;
    tick();
    check("e_release2", 32'(gnt), 32'h0);
    op_valid = '0;
    repeat (4) tick();
    check("e_cnt0", 32'(rsp_cnt[0]), 32'd0);
    check("e_cnt1", 32'(rsp_cnt[1]), 32'd1);
    check("e_cnt2", 32'(rsp_cnt[2]), 32'd3);
    check("e_cnt3", 32'(rsp_cnt[3]), 32'd0);
    check("e_pos", 32'(rsp_pos), 32'h1);

    // reset with two beats in flight
    clr_cnt();
    set_ops(0, 3, 0, 0, 4);
    req      = 4'b0001;
    op_valid = 4'b0001;
    tick();
    check("f_gnt", 32'(gnt), 32'h1);
    tick();
    tick();
    reset    = 1'b0;
    op_valid = '0;
    req      = 4'hF;
    #1;
    check("f_rst_gnt", 32'(gnt), 32'h0);
    check("f_rst_rsp", 32'(rsp_valid), 32'h0);
    check("f_rst_pos", 32'(rsp_pos), 32'h0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("f_regrant", 32'(gnt), 32'h1);
    req = '0;
    repeat (3) tick();
    check("f_lost", 32'(rsp_cnt[0] + rsp_cnt[1] +
                        rsp_cnt[2] + rsp_cnt[3]), 32'd0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
